// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx_serial_paralelo
//   Receive-side serial-to-parallel converter for the PHY. Shifts the line
//   bit stream (MSB first) into a symbol register, finds the byte boundary
//   by sliding-matching the COMMA symbol, and declares the link active once
//   LOCK_COUNT consecutive commas have been seen on aligned boundaries.
//   While active, every aligned non-comma byte is delivered with valid_out;
//   commas are stripped (strobe only, no valid byte).
//
//   Optional feature (macro PHY_RX_LOSS_OF_SYNC_EN): while active, bytes
//   0x00 / 0xFF count as line errors; four in a row drop the link back to
//   SEARCH. Without the macro the link leaves ACTIVE only through reset.
//
// Ports
//   clk_32f      in   bit clock, all logic on its rising edge
//   reset        in   synchronous, active-high
//   data_in      in   serial line bit, MSB of each symbol first
//   data_out     out  [WIDTH-1:0] last received non-comma byte
//   valid_out    out  data_out holds a fresh data byte
//   byte_strobe  out  one-cycle pulse at every aligned boundary in ACTIVE
//   active       out  link locked / aligned
module phy_rx_serial_paralelo #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
   parameter int               LOCK_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             byte_strobe,
   output logic             active
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CC_W  = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CC_W-1:0]  LOCK_VAL = CC_W'(LOCK_COUNT);

   typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             strobe_q, strobe_d;
   logic             active_q, active_d;

   logic             boundary;
   logic             is_comma;
   logic             lose_sync;

`ifdef PHY_RX_LOSS_OF_SYNC_EN
   logic [1:0]       err_cnt_q, err_cnt_d;
   logic             bad_byte;

   assign bad_byte  = (sr_d == '0) || (sr_d == '1);
   // The fourth consecutive bad byte arrives while the counter already holds 3.
   assign lose_sync = (state_q == ACTIVE) && boundary && bad_byte && (err_cnt_q == 2'd3);
`else
   assign lose_sync = 1'b0;
`endif

   // All decisions look at the register contents including this edge's bit.
   assign sr_d     = {sr_q[WIDTH-2:0], data_in};
   assign boundary = (bit_cnt_q == LAST_BIT);
   assign is_comma = (sr_d == COMMA);

   // State register
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         active_q    <= 1'b0;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
         err_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
         active_q    <= active_d;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   // Next-state logic: alignment search, lock counting, loss of sync
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      comma_cnt_d = comma_cnt_q;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
      err_cnt_d   = err_cnt_q;
`endif
      case (state_q)
         SEARCH: begin
            if (is_comma) begin
               // The comma's last bit was just sampled: next edge starts a byte.
               bit_cnt_d   = '0;
               comma_cnt_d = CC_W'(1);
               state_d     = (LOCK_COUNT == 1) ? ACTIVE : COUNT;
            end
         end
         COUNT: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
            if (boundary) begin
               if (is_comma) begin
                  if (comma_cnt_q + 1'b1 >= LOCK_VAL) begin
                     comma_cnt_d = LOCK_VAL;
                     state_d     = ACTIVE;
                  end else begin
                     comma_cnt_d = comma_cnt_q + 1'b1;
                  end
               end else begin
                  // No realignment on the failing byte; sliding search resumes next edge.
                  comma_cnt_d = '0;
                  state_d     = SEARCH;
               end
            end
         end
         ACTIVE: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
            if (boundary) begin
               if (lose_sync) begin
                  err_cnt_d   = '0;
                  comma_cnt_d = '0;
                  state_d     = SEARCH;
               end else if (bad_byte) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end else begin
                  err_cnt_d = '0;
               end
            end
`endif
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // Output logic: registered outputs updated on the edge that samples a byte's LSB
   always_comb begin
      data_d   = data_q;
      valid_d  = valid_q;
      strobe_d = 1'b0;
      active_d = (state_d == ACTIVE);
      if (state_q != ACTIVE) begin
         valid_d = 1'b0;
      end else if (boundary) begin
         strobe_d = 1'b1;
         if (is_comma || lose_sync) begin
            valid_d = 1'b0;
         end else begin
            data_d  = sr_d;
            valid_d = 1'b1;
         end
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = active_q;

endmodule
